// File: rtl/parity_frame_decoder_pkg.sv
// Shared types and helpers for the serial parity frame decoder.
package parity_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Bit counter must hold 0..data_w, so it needs one more code than the data width.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/parity_frame_decoder_accum.sv
// Shift register plus running XOR for one frame's data bits.
// The first bit of a frame is loaded; later bits are shifted in.
module parity_accum #(
  parameter int DATA_W    = 16,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data,
  output logic              parity
);

  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] load_src;
  logic [DATA_W-1:0] shift_src;
  logic              parity_reg;

  // Bits enter at one end and walk toward the other, so after DATA_W bits
  // the first bit sits at bit 0 (LSB-first) or bit DATA_W-1 (MSB-first).
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign load_src  = {{(DATA_W-1){1'b0}}, bit_in};
      assign shift_src = {data_reg[DATA_W-2:0], bit_in};
    end else begin : g_lsb_first
      assign load_src  = {bit_in, {(DATA_W-1){1'b0}}};
      assign shift_src = {bit_in, data_reg[DATA_W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg   <= '0;
      parity_reg <= 1'b0;
    end else if (load) begin
      data_reg   <= load_src;
      parity_reg <= bit_in;
    end else if (shift) begin
      data_reg   <= shift_src;
      parity_reg <= parity_reg ^ bit_in;
    end
  end

  assign data   = data_reg;
  assign parity = parity_reg;

endmodule

// File: rtl/parity_frame_decoder.sv
// Receive-side parity checker: deserialises DATA_W data bits plus a parity bit,
// reports the word with a one-cycle valid pulse and keeps a saturating error count.
module parity_frame_decoder
  import parity_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ODD_PARITY = 0,
  parameter int MSB_FIRST  = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              sof,
  input  logic              err_clr,
  output logic [DATA_W-1:0] frame_out,
  output logic              frame_valid,
  output logic              parity_ok,
  output logic              parity_err,
  output logic              frame_abort,
  output logic              busy,
  output logic [CNT_W-1:0]  err_count
);

  localparam int               CW       = cnt_width(DATA_W);
  localparam logic [CW-1:0]    LAST_CNT = CW'(DATA_W);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;
  localparam logic             PAR_REF  = (ODD_PARITY != 0);

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              acc_load, acc_shift;
  logic              done, abort;
  logic [DATA_W-1:0] acc_data;
  logic              acc_parity;
  logic              ok_now, bad_now;

  logic [DATA_W-1:0] frame_out_reg;
  logic              frame_valid_reg;
  logic              parity_ok_reg;
  logic              parity_err_reg;
  logic              frame_abort_reg;
  logic              busy_reg;
  logic [CNT_W-1:0]  err_count_reg, err_count_next;

  parity_accum #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_accum (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (acc_load),
    .shift  (acc_shift),
    .bit_in (bit_in),
    .data   (acc_data),
    .parity (acc_parity)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A qualified sof always restarts the frame, even on the parity-bit cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    acc_load   = 1'b0;
    acc_shift  = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bit_valid && sof) begin
          acc_load   = 1'b1;
          cnt_next   = CW'(1);
          state_next = RECV;
        end
      end
      RECV: begin
        if (bit_valid) begin
          if (sof) begin
            abort    = 1'b1;
            acc_load = 1'b1;
            cnt_next = CW'(1);
          end else if (cnt_reg == LAST_CNT) begin
            done       = 1'b1;
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            acc_shift = 1'b1;
            cnt_next  = cnt_reg + CW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign ok_now  = ((acc_parity ^ bit_in) == PAR_REF);
  assign bad_now = done && !ok_now;

  // A clear in the same cycle as a failing frame still counts that failure.
  always_comb begin
    err_count_next = err_count_reg;
    if (err_clr) begin
      err_count_next = bad_now ? CNT_W'(1) : '0;
    end else if (bad_now && (err_count_reg != ERR_MAX)) begin
      err_count_next = err_count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_out_reg   <= '0;
      frame_valid_reg <= 1'b0;
      parity_ok_reg   <= 1'b0;
      parity_err_reg  <= 1'b0;
      frame_abort_reg <= 1'b0;
      busy_reg        <= 1'b0;
      err_count_reg   <= '0;
    end else begin
      frame_valid_reg <= done;
      parity_err_reg  <= bad_now;
      frame_abort_reg <= abort;
      busy_reg        <= (state_next == RECV);
      err_count_reg   <= err_count_next;
      if (done) begin
        frame_out_reg <= acc_data;
        parity_ok_reg <= ok_now;
      end
    end
  end

  assign frame_out   = frame_out_reg;
  assign frame_valid = frame_valid_reg;
  assign parity_ok   = parity_ok_reg;
  assign parity_err  = parity_err_reg;
  assign frame_abort = frame_abort_reg;
  assign busy        = busy_reg;
  assign err_count   = err_count_reg;

endmodule

// File: tb/tb_parity_frame_decoder.sv
// Bench for parity_frame_decoder: two 8-bit instances (even/LSB-first/2-bit counter and
// odd/MSB-first/8-bit counter) share one serial stream; a scoreboard checks each output event.
module tb_parity_frame_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic sof = 1'b0;
  logic err_clr = 1'b0;

  logic [7:0] a_frame_out, b_frame_out;
  logic       a_frame_valid, b_frame_valid;
  logic       a_parity_ok, b_parity_ok;
  logic       a_parity_err, b_parity_err;
  logic       a_frame_abort, b_frame_abort;
  logic       a_busy, b_busy;
  logic [1:0] a_err_count;
  logic [7:0] b_err_count;

  always #5 clk = ~clk;

  parity_frame_decoder #(.DATA_W(8), .ODD_PARITY(0), .MSB_FIRST(0), .CNT_W(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .err_clr(err_clr), .frame_out(a_frame_out), .frame_valid(a_frame_valid),
    .parity_ok(a_parity_ok), .parity_err(a_parity_err), .frame_abort(a_frame_abort),
    .busy(a_busy), .err_count(a_err_count)
  );

  parity_frame_decoder #(.DATA_W(8), .ODD_PARITY(1), .MSB_FIRST(1), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .err_clr(err_clr), .frame_out(b_frame_out), .frame_valid(b_frame_valid),
    .parity_ok(b_parity_ok), .parity_err(b_parity_err), .frame_abort(b_frame_abort),
    .busy(b_busy), .err_count(b_err_count)
  );

  typedef struct {
    bit         is_abort;
    int         cyc;
    logic [7:0] da;
    logic [7:0] db;
    logic       oka;
    logic       okb;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Transaction-level reference state
  bit         in_frame = 1'b0;
  int         nbits = 0;
  logic [7:0] word = 8'h00;
  logic [7:0] last_da = 8'h00, last_db = 8'h00;
  logic       last_oka = 1'b0, last_okb = 1'b0;
  logic [1:0] m_erra = 2'd0;
  logic [7:0] m_errb = 8'd0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic drive_bit(input logic b, input logic s, input logic clr, input int gap);
    bit   bad_a, bad_b, fin;
    logic p;
    exp_t e;
    repeat (gap) begin
      bit_valid = 1'b0; sof = 1'($urandom); bit_in = 1'($urandom); err_clr = 1'b0;
      @(negedge clk);
    end
    bit_valid = 1'b1; sof = s; bit_in = b; err_clr = clr;
    bad_a = 1'b0; bad_b = 1'b0; fin = 1'b0;
    if (s) begin
      if (in_frame) begin
        e = '{1'b1, cyc + 1, last_da, last_db, last_oka, last_okb};
        q.push_back(e);
        $display("drive: sof aborts partial frame after %0d bits", nbits);
      end
      in_frame = 1'b1; nbits = 1; word = 8'h00; word[0] = b;
    end else if (in_frame) begin
      if (nbits < 8) begin
        word[nbits] = b; nbits++;
      end else begin
        p = (^word) ^ b;
        last_oka = (p == 1'b0); last_okb = (p == 1'b1);
        bad_a = !last_oka; bad_b = !last_okb;
        last_da = word; last_db = rev8(word);
        fin = 1'b1; in_frame = 1'b0;
      end
    end
    if (clr) begin
      m_erra = bad_a ? 2'd1 : 2'd0;
      m_errb = bad_b ? 8'd1 : 8'd0;
    end else begin
      if (bad_a && m_erra != 2'd3) m_erra = m_erra + 2'd1;
      if (bad_b && m_errb != 8'hFF) m_errb = m_errb + 8'd1;
    end
    if (fin) begin
      e = '{1'b0, cyc + 1, last_da, last_db, last_oka, last_okb};
      q.push_back(e);
      $display("drive: frame 0x%02h parity %0b clr %0b -> ok_a %0b ok_b %0b err_a %0d err_b %0d",
               word, b, clr, last_oka, last_okb, m_erra, m_errb);
    end
    @(negedge clk);
    bit_valid = 1'b0; sof = 1'b0; err_clr = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] w, input int n, input int gap);
    for (int i = 0; i < n; i++) drive_bit(w[i], (i == 0), 1'b0, gap);
  endtask

  task automatic send_frame(input logic [7:0] w, input logic p, input int gap, input logic clr);
    send_data(w, 8, gap);
    drive_bit(p, 1'b0, clr, gap);
  endtask

  task automatic idle_clear();
    bit_valid = 1'b0; sof = 1'b0; err_clr = 1'b1;
    m_erra = 2'd0; m_errb = 8'd0;
    @(negedge clk);
    err_clr = 1'b0;
    $display("drive: standalone err_clr");
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_out"}, a_frame_out, 0);
    check({tag, "_a_fv"}, a_frame_valid, 0);
    check({tag, "_a_ok"}, a_parity_ok, 0);
    check({tag, "_a_perr"}, a_parity_err, 0);
    check({tag, "_a_abort"}, a_frame_abort, 0);
    check({tag, "_a_busy"}, a_busy, 0);
    check({tag, "_a_err"}, a_err_count, 0);
    check({tag, "_b_out"}, b_frame_out, 0);
    check({tag, "_b_fv"}, b_frame_valid, 0);
    check({tag, "_b_ok"}, b_parity_ok, 0);
    check({tag, "_b_perr"}, b_parity_err, 0);
    check({tag, "_b_abort"}, b_frame_abort, 0);
    check({tag, "_b_busy"}, b_busy, 0);
    check({tag, "_b_err"}, b_err_count, 0);
  endtask

  // Monitor: every cycle check busy/err_count; pop the scoreboard on any output pulse.
  always @(posedge clk) begin
    exp_t e;
    logic [5:0] pulses;
    #1;
    if (rst_n) begin
      check("busy_a", a_busy, in_frame);
      check("busy_b", b_busy, in_frame);
      check("err_a", a_err_count, m_erra);
      check("err_b", b_err_count, m_errb);
      pulses = {a_frame_valid, a_frame_abort, a_parity_err,
                b_frame_valid, b_frame_abort, b_parity_err};
      if (pulses != 6'd0) begin
        if (q.size() == 0) begin
          check("unexpected_event", pulses, 0);
        end else begin
          e = q.pop_front();
          $display("event: %s cyc %0d out_a 0x%02h ok_a %0b out_b 0x%02h ok_b %0b",
                   e.is_abort ? "abort" : "frame", cyc, a_frame_out, a_parity_ok,
                   b_frame_out, b_parity_ok);
          check("latency", cyc, e.cyc);
          check("fv_a", a_frame_valid, !e.is_abort);
          check("fv_b", b_frame_valid, !e.is_abort);
          check("abort_a", a_frame_abort, e.is_abort);
          check("abort_b", b_frame_abort, e.is_abort);
          check("perr_a", a_parity_err, !e.is_abort && !e.oka);
          check("perr_b", b_parity_err, !e.is_abort && !e.okb);
          check("out_a", a_frame_out, e.da);
          check("out_b", b_frame_out, e.db);
          check("ok_a", a_parity_ok, e.oka);
          check("ok_b", b_parity_ok, e.okb);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // T1/T2: 0xA5, good then bad even parity; odd instance sees the reverse
    send_frame(8'hA5, 1'b0, 0, 1'b0);
    send_frame(8'hA5, 1'b1, 0, 1'b0);
    // T3: random gaps between bits
    send_frame(8'hA5, 1'b0, 3, 1'b0);
    send_frame(8'h3B, 1'b1, 3, 1'b0);
    // T4: abort after 5 bits, then full 0x3C; then sof on the parity-bit cycle
    send_data(8'h3C, 5, 0);
    send_frame(8'h3C, 1'b0, 0, 1'b0);
    send_data(8'h3C, 8, 1);
    send_frame(8'h81, 1'b0, 0, 1'b0);
    // Back-to-back frames with no dead cycle
    send_frame(8'h7E, 1'b1, 0, 1'b0);
    send_frame(8'h01, 1'b0, 0, 1'b0);
    idle_clear();
    // T5: five bad frames saturate the 2-bit counter, clear coincident with the sixth
    for (int i = 0; i < 6; i++) begin
      w = 8'(8'hF0 + i);
      send_frame(w, ~(^w), 0, (i == 5));
    end
    // T6: asynchronous reset mid-frame
    send_data(8'h5A, 4, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    check("queue_at_reset", q.size(), 0);
    in_frame = 1'b0; nbits = 0;
    m_erra = 2'd0; m_errb = 8'd0;
    last_da = 8'h00; last_db = 8'h00; last_oka = 1'b0; last_okb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(8'h96, 1'b0, 0, 1'b0);
    // Random frames with random parity and gaps
    for (int i = 0; i < 8; i++) begin
      send_frame(8'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b0);
    end

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    check("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
